// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock flop-based FIFO with occupancy count,
// programmable almost-full/almost-empty thresholds, sticky overflow/underflow
// flags, synchronous flush and write-through-when-full.
// Optional build macro SYNC_FIFO_FLAGS_OREG_EN selects a registered read port
// (1-cycle latency, rd_en is a request). Without it the read port is
// show-ahead (dout is the head of queue, rd_en acknowledges it).
module sync_fifo_flags #(
    parameter int DSIZE = 8,
    parameter int ASIZE = 4
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic [DSIZE-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic             flush,
    input  logic             clr_err,
    input  logic [ASIZE:0]   af_thresh,
    input  logic [ASIZE:0]   ae_thresh,
    output logic [DSIZE-1:0] dout,
    output logic             dout_vld,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [ASIZE:0]   count,
    output logic             overflow,
    output logic             underflow
);

    localparam int DEPTH = 2 ** ASIZE;
    localparam int CW    = ASIZE + 1;

    // Storage is deliberately not reset; only pointers and flags are.
    logic [DSIZE-1:0] mem_q [DEPTH];

    logic [ASIZE-1:0] wr_ptr_q, wr_ptr_d;
    logic [ASIZE-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic rd_acc;
    logic wr_acc;

    // A write into a full FIFO is allowed when a read frees a slot in the
    // same cycle; a read on an empty FIFO is always refused.
    assign rd_acc = rd_en & ~empty_q & ~flush;
    assign wr_acc = wr_en & (~full_q | rd_en) & ~flush;

    // Next-state for pointers, occupancy, derived full/empty and error flags.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q & ~clr_err;
        underflow_d = underflow_q & ~clr_err;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
            if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + {{ASIZE{1'b0}}, wr_acc} - {{ASIZE{1'b0}}, rd_acc};
        end

        // Setting an error wins over a simultaneous clr_err.
        if (wr_en & full_q & ~rd_en & ~flush) overflow_d = 1'b1;
        if (rd_en & empty_q & ~flush)         underflow_d = 1'b1;

        full_d  = (count_d == CW'(DEPTH));
        empty_d = (count_d == '0);
    end

    // Control state register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage write on every accepted write.
    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wr_ptr_q] <= din;
    end

    assign count        = count_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;
    // Thresholds above DEPTH can never be reached, so almost_full stays low.
    assign almost_full  = (count_q >= af_thresh);
    assign almost_empty = (count_q <= ae_thresh);

`ifdef SYNC_FIFO_FLAGS_OREG_EN
    logic [DSIZE-1:0] dout_q;
    logic             dout_vld_q;

    // Registered read port: capture head on an accepted read, hold otherwise.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            dout_q     <= '0;
            dout_vld_q <= 1'b0;
        end else begin
            dout_vld_q <= rd_acc;
            if (rd_acc) dout_q <= mem_q[rd_ptr_q];
        end
    end

    assign dout     = dout_q;
    assign dout_vld = dout_vld_q;
`else
    // Show-ahead read port: head of queue is always on dout.
    assign dout     = mem_q[rd_ptr_q];
    assign dout_vld = ~empty_q;
`endif

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Self-checking bench for sync_fifo_flags (DSIZE=8, ASIZE=2, DEPTH=4).
// A data queue acts as scoreboard: accepted writes push the expected word,
// accepted reads pop and compare it against dout.
module tb_sync_fifo_flags;

    localparam int DSIZE = 8;
    localparam int ASIZE = 2;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst_b;
    logic [DSIZE-1:0] din;
    logic             wr_en, rd_en, flush, clr_err;
    logic [ASIZE:0]   af_thresh, ae_thresh;
    logic [DSIZE-1:0] dout;
    logic             dout_vld, full, empty, almost_full, almost_empty;
    logic [ASIZE:0]   count;
    logic             overflow, underflow;

    sync_fifo_flags #(.DSIZE(DSIZE), .ASIZE(ASIZE)) dut (
        .clk          (clk),
        .rst_b        (rst_b),
        .din          (din),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .flush        (flush),
        .clr_err      (clr_err),
        .af_thresh    (af_thresh),
        .ae_thresh    (ae_thresh),
        .dout         (dout),
        .dout_vld     (dout_vld),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    int vectors   = 0;
    int miscompares = 0;

    logic [DSIZE-1:0] sb_q[$];
    logic m_ovf = 1'b0;
    logic m_udf = 1'b0;
    logic m_vld = 1'b0;
    logic [DSIZE-1:0] m_dout = '0;
    logic m_dout_known = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        $display("vec %0d %s obs=%0h exp=%0h", vectors, tag, obs, exp);
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        int n;
        n = sb_q.size();
        chk({tag, ".count"},     32'(count),        32'(n));
        chk({tag, ".full"},      32'(full),         32'(n == DEPTH));
        chk({tag, ".empty"},     32'(empty),        32'(n == 0));
        chk({tag, ".overflow"},  32'(overflow),     32'(m_ovf));
        chk({tag, ".underflow"}, 32'(underflow),    32'(m_udf));
        chk({tag, ".afull"},     32'(almost_full),  32'(n >= int'(af_thresh)));
        chk({tag, ".aempty"},    32'(almost_empty), 32'(n <= int'(ae_thresh)));
`ifdef SYNC_FIFO_FLAGS_OREG_EN
        chk({tag, ".dout_vld"},  32'(dout_vld),     32'(m_vld));
        if (m_dout_known) chk({tag, ".dout_reg"}, 32'(dout), 32'(m_dout));
`else
        chk({tag, ".dout_vld"},  32'(dout_vld),     32'(n != 0));
`endif
    endtask

    // One clock cycle of stimulus; model updated from the spec rules.
    task automatic cycle(input string tag, input logic w, input logic r,
                         input logic [DSIZE-1:0] d, input logic fl, input logic ce);
        logic racc, wacc;
        logic [DSIZE-1:0] popped;
        int n;
        n = sb_q.size();
        wr_en = w; rd_en = r; din = d; flush = fl; clr_err = ce;
        racc = r && (n > 0) && !fl;
        wacc = w && ((n < DEPTH) || r) && !fl;
        #1;
`ifndef SYNC_FIFO_FLAGS_OREG_EN
        if (racc) chk({tag, ".dout_head"}, 32'(dout), 32'(sb_q[0]));
`endif
        m_ovf = (m_ovf && !ce) || (w && (n == DEPTH) && !r && !fl);
        m_udf = (m_udf && !ce) || (r && (n == 0) && !fl);
        @(posedge clk);
        #1;
        wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; clr_err = 1'b0;
        popped = '0;
        if (fl) begin
            sb_q.delete();
        end else begin
            if (racc) popped = sb_q.pop_front();
            if (wacc) sb_q.push_back(d);
        end
        m_vld = racc;
        if (racc) begin
            m_dout = popped;
            m_dout_known = 1'b1;
        end
        check_state(tag);
    endtask

    initial begin
        rst_b = 1'b0; din = '0; wr_en = 1'b0; rd_en = 1'b0;
        flush = 1'b0; clr_err = 1'b0; af_thresh = 3'd0; ae_thresh = 3'd1;
        #12;
        // Reset values, including almost_full with a zero threshold.
        chk("rst.almost_full_thr0", 32'(almost_full), 32'd1);
        af_thresh = 3'd3;
        #1;
        check_state("rst");
        @(negedge clk);
        rst_b = 1'b1;
        @(posedge clk); #1;

        // 1: fill with four words, then drain in order.
        cycle("t1.w0", 1, 0, 8'h11, 0, 0);
        chk("t1.aempty_at1", 32'(almost_empty), 32'd1);
        cycle("t1.w1", 1, 0, 8'h22, 0, 0);
        chk("t1.aempty_at2", 32'(almost_empty), 32'd0);
        cycle("t1.w2", 1, 0, 8'h33, 0, 0);
        chk("t1.afull_at3", 32'(almost_full), 32'd1);
        cycle("t1.w3", 1, 0, 8'h44, 0, 0);
        chk("t1.full_at4", 32'(full), 32'd1);
        for (int i = 0; i < 4; i++) cycle("t1.rd", 0, 1, 8'h00, 0, 0);
        chk("t1.empty_end", 32'(empty), 32'd1);

        // 2: write-through when full.
        cycle("t2.w0", 1, 0, 8'h11, 0, 0);
        cycle("t2.w1", 1, 0, 8'h22, 0, 0);
        cycle("t2.w2", 1, 0, 8'h33, 0, 0);
        cycle("t2.w3", 1, 0, 8'h44, 0, 0);
        cycle("t2.wr_rd_full", 1, 1, 8'h55, 0, 0);
        chk("t2.count_stays4", 32'(count), 32'd4);
        // Thresholds above DEPTH never raise almost_full.
        af_thresh = 3'd5;
        #1;
        chk("t2.afull_thr5", 32'(almost_full), 32'd0);
        af_thresh = 3'd3;
        for (int i = 0; i < 4; i++) cycle("t2.rd", 0, 1, 8'h00, 0, 0);

        // 3: sticky error flags and clr_err.
        for (int i = 0; i < 4; i++) cycle("t3.fill", 1, 0, 8'(8'h11 * (i + 1)), 0, 0);
        cycle("t3.ovf", 1, 0, 8'h66, 0, 0);
        chk("t3.overflow_set", 32'(overflow), 32'd1);
        for (int i = 0; i < 4; i++) cycle("t3.rd", 0, 1, 8'h00, 0, 0);
        cycle("t3.udf", 0, 1, 8'h00, 0, 0);
        chk("t3.underflow_set", 32'(underflow), 32'd1);
        cycle("t3.clr", 0, 0, 8'h00, 0, 1);
        chk("t3.ovf_cleared", 32'(overflow), 32'd0);
        for (int i = 0; i < 4; i++) cycle("t3.fill2", 1, 0, 8'(8'h21 + i), 0, 0);
        cycle("t3.clr_vs_ovf", 1, 0, 8'h77, 0, 1);
        chk("t3.set_wins", 32'(overflow), 32'd1);
        cycle("t3.clr2", 0, 0, 8'h00, 0, 1);
        for (int i = 0; i < 4; i++) cycle("t3.rd2", 0, 1, 8'h00, 0, 0);

        // 4: interleaved traffic wrapping the pointers twice.
        cycle("t4.empty_wr_rd", 1, 1, 8'hC0, 0, 0);
        chk("t4.underflow", 32'(underflow), 32'd1);
        for (int i = 1; i < 8; i++) cycle("t4.wr_rd", 1, 1, 8'(8'hC0 + i), 0, 0);
        cycle("t4.last_rd", 0, 1, 8'h00, 0, 0);
        cycle("t4.clr", 0, 0, 8'h00, 0, 1);

        // 5: flush with concurrent requests, then asynchronous reset.
        for (int i = 0; i < 3; i++) cycle("t5.fill", 1, 0, 8'(8'h51 + i), 0, 0);
        cycle("t5.flush", 1, 1, 8'hEE, 1, 0);
        chk("t5.count0", 32'(count), 32'd0);
        cycle("t5.wa5", 1, 0, 8'hA5, 0, 0);
        cycle("t5.ra5", 0, 1, 8'h00, 0, 0);
        cycle("t5.w1", 1, 0, 8'h61, 0, 0);
        cycle("t5.w2", 1, 0, 8'h62, 0, 0);
        #2;
        rst_b = 1'b0;
        #1;
        sb_q.delete();
        m_ovf = 1'b0; m_udf = 1'b0; m_vld = 1'b0; m_dout_known = 1'b0;
        chk("t5.async_count", 32'(count), 32'd0);
        check_state("t5.async_rst");
        @(negedge clk);
        rst_b = 1'b1;
        @(posedge clk); #1;

        // 6: registered-read style check (also valid show-ahead traffic).
        cycle("t6.w0", 1, 0, 8'h11, 0, 0);
        cycle("t6.w1", 1, 0, 8'h22, 0, 0);
        cycle("t6.r0", 0, 1, 8'h00, 0, 0);
        cycle("t6.r1", 0, 1, 8'h00, 0, 0);
        cycle("t6.idle", 0, 0, 8'h00, 0, 0);
        cycle("t6.idle2", 0, 0, 8'h00, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sync_fifo_flags.md
Name: sync_fifo_flags

Overview:
Parametrised successor to the team's single-clock flop-based FIFO. Adds:
- an explicit occupancy count
- programmable almost-full and almost-empty thresholds
- sticky overflow/underflow error flags
- synchronous flush
- write-through-when-full
Used between pipeline stages that need back-pressure ahead of full. Same clock domain on both sides.

Parameters:
DSIZE, 8, data word width in bits (>=1)
ASIZE, 4, address width; DEPTH = 2**ASIZE entries (ASIZE>=1)

Ports:
clk  input  1  clock, all logic on rising edge
rst_b  input  1  asynchronous active-low reset
din  input  DSIZE  write data
wr_en  input  1  write request
rd_en  input  1  read request
flush  input  1  synchronous clear of contents and pointers
clr_err  input  1  synchronous clear of sticky error flags
af_thresh  input  ASIZE+1  almost-full threshold, unsigned
ae_thresh  input  ASIZE+1  almost-empty threshold, unsigned
dout  output  DSIZE  read data
dout_vld  output  1  dout holds valid head-of-queue data
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= af_thresh
almost_empty  output  1  count <= ae_thresh
count  output  ASIZE+1  current occupancy, 0..DEPTH
overflow  output  1  sticky: write refused
underflow  output  1  sticky: read refused

Behaviour:
Reset:
- Clock: one clock, clk. Reset: rst_b is asynchronous and active-low.
- rst_b low clears the following immediately, independent of clk: rd_ptr=0, wr_ptr=0, count=0, full=0, empty=1, overflow=0, underflow=0, dout_vld=0.
- Storage array is not reset. dout is don't-care while empty.
- almost_* flags are combinational from registered count and the threshold ports. At reset: almost_empty=1; almost_full=(af_thresh==0).

Accept rules:
- rd_acc = rd_en & ~empty & ~flush.
- wr_acc = wr_en & (~full | rd_en) & ~flush. A write is accepted when full if a read is accepted the same cycle.
- On empty with rd_en&wr_en: read refused, write accepted.

Pointers and storage:
- Pointers are ASIZE bits and wrap naturally from DEPTH-1 to 0.
- On wr_acc: mem[wr_ptr]<=din; wr_ptr+1.
- On rd_acc: rd_ptr+1.

Count:
- count <= count + wr_acc - rd_acc, computed in ASIZE+1 bits. It never exceeds DEPTH and never goes below 0.
- full and empty are registered, derived from next count. They are valid in the same cycle as count.

Flush:
- Takes priority over rd_en and wr_en.
- Next cycle: pointers=0, count=0, empty=1, full=0.
- Requests in the flush cycle are discarded and set no error flags.

Errors:
- overflow <= 1 when wr_en & full & ~rd_en & ~flush.
- underflow <= 1 when rd_en & empty & ~flush.
- clr_err clears both. If clr_err and a new error occur in the same cycle, the set wins.
- Errors never alter FIFO state.

Thresholds:
- Thresholds may change any cycle and take effect combinationally.
- af_thresh > DEPTH means almost_full is never asserted.

Read path (default, macro absent):
- Show-ahead: dout = mem[rd_ptr], combinational.
- dout_vld = ~empty.
- Zero read latency; rd_en acknowledges the word currently on dout.

Optional Feature:
Macro: SYNC_FIFO_FLAGS_OREG_EN

Defined (registered output):
- On rd_acc, dout <= mem[rd_ptr] at the clock edge.
- dout_vld <= 1 for exactly the cycle after each rd_acc, otherwise 0.
- Read latency is 1 cycle. dout holds its last value when no read occurs.
- dout_vld is cleared by reset and by flush.
- rd_en is a request, not an acknowledge.

Undefined:
- Show-ahead behaviour as above.
- Flag, count and error behaviour are identical in both builds.

Test Plan:
(DSIZE=8, ASIZE=2, DEPTH=4; macro absent unless stated)
1. Reset, then write 0x11,0x22,0x33,0x44 on consecutive cycles with af_thresh=3, ae_thresh=1:
   - count goes 1,2,3,4.
   - almost_empty drops when count=2.
   - almost_full rises at count=3.
   - full=1 after the 4th write.
   - Then read 4 cycles: dout shows 0x11,0x22,0x33,0x44, each visible before its rd_en; empty=1 at the end.
2. Full FIFO, wr_en=1 with din=0x55 and rd_en=1 in the same cycle:
   - count stays 4, full stays 1, overflow stays 0.
   - Draining yields 0x22,0x33,0x44,0x55.
3. Full FIFO, wr_en=1, rd_en=0:
   - overflow=1 next cycle, count stays 4, contents unchanged.
   - Then an empty FIFO with rd_en=1: underflow=1.
   - Then clr_err=1: both flags 0 next cycle.
   - clr_err in the same cycle as a new overflow leaves overflow=1.
4. Write 8 and read 8 interleaved (pointer wrap twice), including an rd_en&wr_en cycle while empty:
   - Write accepted, read refused, underflow=1.
   - Data order preserved across the wrap.
5. FIFO holding 3 entries; flush=1 together with wr_en=1 and rd_en=1:
   - Next cycle count=0, empty=1, no error flags.
   - A subsequent write of 0xA5 reads back 0xA5.
   - Assert rst_b low mid-stream asynchronously: outputs go to reset values without a clock edge.
6. With SYNC_FIFO_FLAGS_OREG_EN defined: write 0x11,0x22, then rd_en for 2 cycles.
   - dout_vld is high on the two following cycles, with dout=0x11 then 0x22.
   - dout_vld=0 otherwise.
   - dout holds 0x22 afterwards.
